// File: rtl/risc_pkg.sv
// Shared widths and encodings for the 16-bit RISC core.
// Used by the fetch unit and top_datapath alike.
package risc_pkg;

    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] RESET_PC_DEF = '0;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 3;
    localparam int FUNCT_W  = 3;
    localparam int IMM_W    = DATA_W - OPCODE_W - 2 * REG_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries of {pc, instr}, wrap-around pointers,
// synchronous flush, zero on the read port when empty.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign valid   = count_q != '0;
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = valid ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Issue gating upstream must make this unreachable.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !do_pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC generation, one read in flight, prefetch FIFO,
// redirect with drop of a stale in-flight response.
module instruction_fetch_unit
    import risc_pkg::*;
#(
    parameter int            N        = DATA_W,
    parameter int            DEPTH    = 4,
    parameter logic [N-1:0]  RESET_PC = N'(RESET_PC_DEF)
) (
    input  logic                     Clock,
    input  logic                     Reset,
    output logic                     Imem_req,
    output logic [N-1:0]             Imem_addr,
    input  logic                     Imem_rvalid,
    input  logic [N-1:0]             Imem_rdata,
    input  logic                     Redirect,
    input  logic [N-1:0]             Redirect_PC,
    output logic [N-1:0]             Instruction,
    output logic [N-1:0]             Instr_PC,
    output logic                     Instr_valid,
    input  logic                     Instr_ready,
    output logic [$clog2(DEPTH):0]   Fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e   state_q, state_d;
    logic [N-1:0]   fetch_pc_q, fetch_pc_d;
    logic [N-1:0]   req_pc_q, req_pc_d;
    logic           out_q, out_d;
    logic [CW:0]    occ;
    logic           issue;
    logic           push;
    logic           pop;
    logic [2*N-1:0] head;

    // Count the in-flight read as occupied so a push can never overflow.
    assign occ   = {1'b0, Fifo_count} + {{CW{1'b0}}, out_q};
    assign issue = (state_q == S_FETCH) && !Redirect
                && (!out_q || Imem_rvalid)
                && (occ < (CW+1)'(DEPTH));
    assign push  = (state_q == S_FETCH) && out_q && Imem_rvalid && !Redirect;
    assign pop   = Instr_valid && Instr_ready && !Redirect;

    assign Imem_req    = issue;
    assign Imem_addr   = issue ? fetch_pc_q : '0;
    assign Instr_PC    = head[2*N-1:N];
    assign Instruction = head[N-1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        out_d      = out_q;
        if (Imem_rvalid) out_d = 1'b0;
        if (issue) begin
            out_d      = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
        end
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (Redirect && out_q && !Imem_rvalid) state_d = S_DROP;
            S_DROP:  if (Imem_rvalid) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
        if (Redirect) fetch_pc_d = Redirect_PC;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            out_q      <= out_d;
        end
    end

    fetch_fifo #(
        .W     (2 * N),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (Clock),
        .rst_n (Reset),
        .flush (Redirect),
        .push  (push),
        .wdata ({req_pc_q, Imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .valid (Instr_valid),
        .count (Fifo_count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-programmable
// instruction memory model returning addr ^ 16'hA052.
module tb_instruction_fetch_unit;
    import risc_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Imem_req;
    logic [15:0] Imem_addr;
    logic        Imem_rvalid = 1'b0;
    logic [15:0] Imem_rdata = '0;
    logic        Redirect = 1'b0;
    logic [15:0] Redirect_PC = '0;
    logic [15:0] Instruction;
    logic [15:0] Instr_PC;
    logic        Instr_valid;
    logic        Instr_ready = 1'b1;
    logic [2:0]  Fifo_count;

    int checks = 0;
    int errors = 0;

    int          lat = 1;
    bit          pend = 0;
    logic [15:0] paddr = '0;
    int          pwait = 0;
    bit          force_rv = 0;
    logic [15:0] force_data = '0;
    bit          last_req = 0;

    logic [15:0] issued[$];
    logic [15:0] pop_pc[$];
    logic [15:0] pop_ins[$];

    instruction_fetch_unit dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Imem_req    (Imem_req),
        .Imem_addr   (Imem_addr),
        .Imem_rvalid (Imem_rvalid),
        .Imem_rdata  (Imem_rdata),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .Instruction (Instruction),
        .Instr_PC    (Instr_PC),
        .Instr_valid (Instr_valid),
        .Instr_ready (Instr_ready),
        .Fifo_count  (Fifo_count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive memory, sample at negedge+1, end at posedge+1.
    task automatic step();
        bit rv_now;
        @(negedge Clock);
        rv_now      = force_rv || (pend && pwait == 0);
        Imem_rvalid = rv_now;
        Imem_rdata  = force_rv ? force_data
                    : (rv_now ? (paddr ^ 16'hA052) : 16'h0000);
        #1;
        last_req = Imem_req;
        if (Instr_valid && Instr_ready && !Redirect) begin
            pop_pc.push_back(Instr_PC);
            pop_ins.push_back(Instruction);
        end
        if (Imem_req) issued.push_back(Imem_addr);
        if (pend) begin
            if (rv_now && !force_rv) pend = 0;
            else if (pwait > 0) pwait--;
        end
        if (Imem_req) begin
            pend  = 1;
            paddr = Imem_addr;
            pwait = lat - 1;
        end
        @(posedge Clock);
        #1;
        Imem_rvalid = 1'b0;
    endtask

    task automatic clear_logs();
        issued.delete();
        pop_pc.delete();
        pop_ins.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        pend  = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        clear_logs();
    endtask

    initial begin
        int n;
        logic [15:0] e;
        #1 Reset = 1'b0;
        #2;
        check("rst_req",   32'(Imem_req),    0);
        check("rst_addr",  32'(Imem_addr),   0);
        check("rst_valid", 32'(Instr_valid), 0);
        check("rst_instr", 32'(Instruction), 0);
        check("rst_pc",    32'(Instr_PC),    0);
        check("rst_count", 32'(Fifo_count),  0);

        // 1: streaming with 1-cycle memory
        do_reset();
        repeat (8) step();
        check("t1_nissue", issued.size(), 7);
        for (int i = 0; i < issued.size(); i++)
            check("t1_addr", 32'(issued[i]), i);
        check("t1_havepop", 32'(pop_pc.size() > 0), 1);
        if (pop_pc.size() > 0) begin
            check("t1_pc0",  32'(pop_pc[0]),  0);
            check("t1_ins0", 32'(pop_ins[0]), 32'h0000A052);
        end

        // 2: back-pressure from empty
        Instr_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check("t2_nissue", issued.size(), 4);
        for (int i = 0; i < issued.size(); i++)
            check("t2_addr", 32'(issued[i]), i);
        check("t2_count", 32'(Fifo_count), 4);
        check("t2_noreq", 32'(last_req), 0);
        check("t2_head",  32'(Instruction), 32'h0000A052);
        Instr_ready = 1'b1;
        n = 0;
        while ((pop_pc.size() < 4 || issued.size() < 5) && n < 20) begin
            step();
            n++;
        end
        check("t2_drained", 32'(pop_pc.size() >= 4 && issued.size() >= 5), 1);
        if (pop_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                e = 16'(i);
                check("t2_pop_pc",  32'(pop_pc[i]),  32'(e));
                check("t2_pop_ins", 32'(pop_ins[i]), 32'(e ^ 16'hA052));
            end
        end
        if (issued.size() >= 5) check("t2_resume", 32'(issued[4]), 4);

        // 3: redirect with a read in flight, latency 3
        lat = 3;
        n = 0;
        step();
        while (!last_req && n < 10) begin
            step();
            n++;
        end
        check("t3_issued", 32'(last_req), 1);
        clear_logs();
        Redirect    = 1'b1;
        Redirect_PC = 16'h0100;
        step();
        Redirect = 1'b0;
        check("t3_drop",  32'(dut.state_q), 32'(S_DROP));
        check("t3_flush", 32'(Instr_valid), 0);
        n = 0;
        while (issued.size() < 1 && n < 20) begin
            step();
            n++;
        end
        check("t3_reissue", 32'(issued.size() >= 1), 1);
        if (issued.size() >= 1) check("t3_addr", 32'(issued[0]), 32'h0100);
        check("t3_nostale", 32'(Fifo_count), 0);
        n = 0;
        while (pop_pc.size() < 1 && n < 20) begin
            step();
            n++;
        end
        check("t3_delivered", 32'(pop_pc.size() >= 1), 1);
        if (pop_pc.size() >= 1) begin
            check("t3_pc",  32'(pop_pc[0]),  32'h0100);
            check("t3_ins", 32'(pop_ins[0]), 32'hA152);
        end

        // 4: PC wrap across 16'hFFFF
        lat = 1;
        clear_logs();
        Redirect    = 1'b1;
        Redirect_PC = 16'hFFFE;
        step();
        Redirect = 1'b0;
        n = 0;
        while ((issued.size() < 4 || pop_pc.size() < 4) && n < 30) begin
            step();
            n++;
        end
        check("t4_done", 32'(issued.size() >= 4 && pop_pc.size() >= 4), 1);
        if (issued.size() >= 4 && pop_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                e = 16'hFFFE + 16'(i);
                check("t4_addr", 32'(issued[i]), 32'(e));
                check("t4_pc",   32'(pop_pc[i]), 32'(e));
                check("t4_ins",  32'(pop_ins[i]), 32'(e ^ 16'hA052));
            end
        end

        // 5: full FIFO, stray rvalid, push+pop at occupancy, async reset
        Instr_ready = 1'b0;
        repeat (10) step();
        check("t5_full", 32'(Fifo_count), 4);
        force_rv   = 1;
        force_data = 16'h1234;
        step();
        force_rv = 0;
        check("t5_stray", 32'(Fifo_count), 4);
        Instr_ready = 1'b1;
        step();
        check("t5_pop1", 32'(Fifo_count), 3);
        step();
        check("t5_pop2", 32'(Fifo_count), 2);
        step();
        check("t5_pushpop", 32'(Fifo_count), 2);

        Instr_ready = 1'b0;
        lat = 3;
        n = 0;
        step();
        while (!last_req && n < 10) begin
            step();
            n++;
        end
        step();
        check("t5_prevalid", 32'(Instr_valid), 1);
        #2 Reset = 1'b0;
        #1;
        check("t5_req",   32'(Imem_req),    0);
        check("t5_addr",  32'(Imem_addr),   0);
        check("t5_valid", 32'(Instr_valid), 0);
        check("t5_instr", 32'(Instruction), 0);
        check("t5_pc",    32'(Instr_PC),    0);
        check("t5_count", 32'(Fifo_count),  0);
        pend = 0;
        @(posedge Clock);
        #1 Reset = 1'b1;
        clear_logs();
        force_rv   = 1;
        force_data = 16'h5555;
        step();
        force_rv = 0;
        check("t5_late_cnt", 32'(Fifo_count),  0);
        check("t5_late_vld", 32'(Instr_valid), 0);
        lat = 1;
        Instr_ready = 1'b1;
        n = 0;
        while (issued.size() < 1 && n < 10) begin
            step();
            n++;
        end
        check("t5_restart", 32'(issued.size() >= 1), 1);
        if (issued.size() >= 1) check("t5_rst_pc", 32'(issued[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
